multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Sequencing FSM that turns the 16+4-instruction CPU datapath (PC, inst_rom, regfile, alu, data_ram) into a multi-cycle machine with IF/ID/EXE/MEM/WB states.
- Memories become handshaked (req/ready with wait states).
- The block gates PC update, IR/MDR loads, regfile write and data-memory write, and counts retired instructions.
- Sits beside the datapath; its inputs are decode flags derived from the instruction register.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low; the only clock/reset pair.
- imem_ready  in  1  instruction memory has valid data this cycle.
- dmem_ready  in  1  data memory has completed the read/write this cycle.
- is_jbr  in  1  decoded J/BEQ/BNE (taken or not); PC target already resolved by the datapath.
- is_load  in  1  decoded LW.
- is_store  in  1  decoded SW.
- is_wreg  in  1  decoded instruction writes the regfile (ALU/LUI/ANDI class).
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  latch instruction register.
- alu_en  out  1  latch ALU result register.
- dmem_req  out  1  data memory request.
- dmem_wen  out  1  data memory write enable.
- mdr_load  out  1  latch load data.
- rf_wen  out  1  regfile write strobe.
- pc_wen  out  1  PC <= next_pc.
- state  out  3  current state encoding.
- retired  out  RETIRE_W  retired-instruction count.

Behaviour:
- States and encodings: IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- Reset (async, resetn=0):
  - state=IDLE, retired=0.
  - All strobe outputs are 0 immediately, including mid-instruction. No partial PC, regfile or memory write may occur.
- IDLE: always goes to IF next cycle (one bubble after reset release).
- IF:
  - imem_req=1.
  - If imem_ready=0, stay in IF.
  - If imem_ready=1, ir_load=1 in the same cycle and go to ID.
- ID (one cycle), priority is_jbr > is_load > is_store > is_wreg:
  - is_jbr: pc_wen=1, retire, go to IF.
  - Otherwise go to EXE.
- EXE (one cycle):
  - alu_en=1.
  - is_load or is_store: go to MEM.
  - Else is_wreg: go to WB.
  - Else (no-effect instruction): pc_wen=1, retire, go to IF.
- MEM:
  - dmem_req=1 for the whole stay; dmem_wen = is_store & ~is_load.
  - If dmem_ready=0, hold indefinitely with no timeout.
  - On dmem_ready=1, load: mdr_load=1, go to WB.
  - On dmem_ready=1, store: pc_wen=1, retire, go to IF.
- WB (one cycle): rf_wen=1, pc_wen=1, retire, go to IF.
- Strobe generation: all strobes are combinational from state plus inputs (Mealy on ready). Each strobe is high for at most one cycle per instruction, except imem_req and dmem_req, which stay high while waiting.
- Decode inputs: sampled only in ID/EXE/MEM. The datapath holds them stable from ir_load until the next IF.
- Retire: retired increments by 1 on the clock edge of every pc_wen cycle and wraps from 2^RETIRE_W-1 to 0.
- Latencies with zero-wait memories:
  - jump/branch: 2 cycles.
  - ALU op: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- A ready input asserted outside its own state is ignored.

Optional Feature:
- Macro: CTRL_STEP_MODE_EN.
- Defined: adds input port step (1 bit).
  - When entering IF, the FSM holds imem_req=0 until a cycle with step=1, then fetches normally.
  - Exactly one instruction executes per step pulse.
  - step held high gives free-running execution.
  - A step pulse during a non-IF state is ignored.
- Undefined: no step port; IF issues imem_req immediately.

Decomposition:
- Package cpu_ctrl_pkg: state encoding constants (CS_IDLE..CS_WB), STATE_W=3.
- Sub-module ctrl_retire_cnt: parameterised RETIRE_W counter with async active-low clear and increment enable, instantiated once.

Test Plan:
- Reset release, ADDU with imem_ready/dmem_ready tied to 1 -> states 0,1,2,3,5,1. rf_wen and pc_wen both high in the WB cycle, retired=1.
- LW with dmem_ready low for 3 MEM cycles -> dmem_req high for 4 cycles, dmem_wen=0, mdr_load pulse on the 4th, then WB; total 8 cycles from IF, retired+1.
- SW with imem_ready low for 2 IF cycles -> ir_load only on the 3rd IF cycle, dmem_wen=1 in MEM, no rf_wen, pc_wen in MEM.
- BEQ (is_jbr=1 with is_wreg=1 forced) -> pc_wen in ID, no alu_en/rf_wen, back to IF after 2 cycles.
- resetn dropped in MEM while dmem_req=1 -> dmem_req/dmem_wen fall asynchronously, state=0, retired=0. Force retired=2^32-1 and run one ALU op -> retired=0.
- CTRL_STEP_MODE_EN: step low 10 cycles -> state stays 1, imem_req=0. One step pulse -> exactly one instruction retires, FSM parks in IF.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared state encoding for the multi-cycle CPU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int STATE_W = 3;

    // Codes 6 and 7 are unused; the sequencer treats them as illegal.
    typedef enum logic [STATE_W-1:0] {
        CS_IDLE = 3'd0,
        CS_IF   = 3'd1,
        CS_ID   = 3'd2,
        CS_EXE  = 3'd3,
        CS_MEM  = 3'd4,
        CS_WB   = 3'd5
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_retire_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_retire_cnt
//  Description : Retired-instruction counter, async active-low clear,
//                increment enable, wraps at 2^RETIRE_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_retire_cnt #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_inc,
    output logic [RETIRE_W-1:0] o_count
);

    logic [RETIRE_W-1:0] r_count;

    // Count one per retiring instruction; natural overflow provides the wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + RETIRE_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl
//  Description : IF/ID/EXE/MEM/WB sequencer for the multi-cycle CPU. Gates
//                PC update, IR/MDR loads, regfile and data-memory writes,
//                handshakes with wait-stated memories, counts retirements.
//  Options     : CTRL_STEP_MODE_EN - adds a 'step' input; each fetch waits
//                for step=1, giving one instruction per step pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                is_jbr,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                is_wreg,
`ifdef CTRL_STEP_MODE_EN
    input  logic                step,
`endif
    output logic                imem_req,
    output logic                ir_load,
    output logic                alu_en,
    output logic                dmem_req,
    output logic                dmem_wen,
    output logic                mdr_load,
    output logic                rf_wen,
    output logic                pc_wen,
    output logic [STATE_W-1:0]  state,
    output logic [RETIRE_W-1:0] retired
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    logic        w_fetch_ok;

`ifdef CTRL_STEP_MODE_EN
    logic        r_step_armed;

    // Remember a step seen in IF so the fetch survives imem wait states;
    // step pulses outside IF are dropped by clearing on every other state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step_armed <= 1'b0;
        end else if (r_state == CS_IF) begin
            if (ir_load) begin
                r_step_armed <= 1'b0;
            end else if (step) begin
                r_step_armed <= 1'b1;
            end
        end else begin
            r_step_armed <= 1'b0;
        end
    end

    assign w_fetch_ok = step | r_step_armed;
`else
    assign w_fetch_ok = 1'b1;
`endif

    // State register; async reset parks in IDLE so every strobe drops at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= CS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode; strobes are Mealy on the ready inputs.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_wen     = 1'b0;
        mdr_load     = 1'b0;
        rf_wen       = 1'b0;
        pc_wen       = 1'b0;
        case (r_state)
            CS_IDLE: begin
                w_next_state = CS_IF;
            end
            CS_IF: begin
                imem_req = w_fetch_ok;
                if (w_fetch_ok && imem_ready) begin
                    ir_load      = 1'b1;
                    w_next_state = CS_ID;
                end
            end
            CS_ID: begin
                // Jumps/branches finish here: target is already resolved.
                if (is_jbr) begin
                    pc_wen       = 1'b1;
                    w_next_state = CS_IF;
                end else begin
                    w_next_state = CS_EXE;
                end
            end
            CS_EXE: begin
                alu_en = 1'b1;
                if (is_load || is_store) begin
                    w_next_state = CS_MEM;
                end else if (is_wreg) begin
                    w_next_state = CS_WB;
                end else begin
                    pc_wen       = 1'b1;
                    w_next_state = CS_IF;
                end
            end
            CS_MEM: begin
                // Request held for the whole stay; no timeout on dmem_ready.
                dmem_req = 1'b1;
                dmem_wen = is_store & ~is_load;
                if (dmem_ready) begin
                    if (is_load) begin
                        mdr_load     = 1'b1;
                        w_next_state = CS_WB;
                    end else begin
                        pc_wen       = 1'b1;
                        w_next_state = CS_IF;
                    end
                end
            end
            CS_WB: begin
                rf_wen       = 1'b1;
                pc_wen       = 1'b1;
                w_next_state = CS_IF;
            end
            default: begin
                w_next_state = CS_IDLE;
            end
        endcase
    end

    assign state = r_state;

    ctrl_retire_cnt #(
        .RETIRE_W (RETIRE_W)
    ) u_retire (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (pc_wen),
        .o_count (retired)
    );

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_cycle_ctrl
//  Description : Directed, table-driven bench for multi_cycle_ctrl plus
//                hand-written async-reset and step-mode sequences. A second
//                instance with a 2-bit counter exercises retire wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_ready, dmem_ready;
    logic        is_jbr, is_load, is_store, is_wreg;
    logic        imem_req, ir_load, alu_en, dmem_req, dmem_wen;
    logic        mdr_load, rf_wen, pc_wen;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        w_imem_req, w_ir_load, w_alu_en, w_dmem_req, w_dmem_wen;
    logic        w_mdr_load, w_rf_wen, w_pc_wen;
    logic [2:0]  w_state;
    logic [1:0]  w_retired;

`ifdef CTRL_STEP_MODE_EN
    logic        step;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.RETIRE_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_jbr(is_jbr), .is_load(is_load), .is_store(is_store), .is_wreg(is_wreg),
`ifdef CTRL_STEP_MODE_EN
        .step(step),
`endif
        .imem_req(imem_req), .ir_load(ir_load), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .mdr_load(mdr_load),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .state(state), .retired(retired)
    );

    multi_cycle_ctrl #(.RETIRE_W(2)) dut_w (
        .clk(clk), .resetn(resetn),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_jbr(is_jbr), .is_load(is_load), .is_store(is_store), .is_wreg(is_wreg),
`ifdef CTRL_STEP_MODE_EN
        .step(step),
`endif
        .imem_req(w_imem_req), .ir_load(w_ir_load), .alu_en(w_alu_en),
        .dmem_req(w_dmem_req), .dmem_wen(w_dmem_wen), .mdr_load(w_mdr_load),
        .rf_wen(w_rf_wen), .pc_wen(w_pc_wen), .state(w_state), .retired(w_retired)
    );

    // {imem_req, ir_load, alu_en, dmem_req, dmem_wen, mdr_load, rf_wen, pc_wen}
    localparam logic [7:0] S_NONE  = 8'b0000_0000;
    localparam logic [7:0] S_IFF   = 8'b1100_0000;
    localparam logic [7:0] S_IFW   = 8'b1000_0000;
    localparam logic [7:0] S_EXE   = 8'b0010_0000;
    localparam logic [7:0] S_EXEPC = 8'b0010_0001;
    localparam logic [7:0] S_MEMW  = 8'b0001_0000;
    localparam logic [7:0] S_MEMLD = 8'b0001_0100;
    localparam logic [7:0] S_MEMST = 8'b0001_1001;
    localparam logic [7:0] S_WB    = 8'b0000_0011;
    localparam logic [7:0] S_PC    = 8'b0000_0001;

    typedef struct packed {
        logic        ir;
        logic        dr;
        logic        jbr;
        logic        ld;
        logic        st;
        logic        wr;
        logic [2:0]  exp_state;
        logic [7:0]  exp_strb;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] strobes();
        return {imem_req, ir_load, alu_en, dmem_req, dmem_wen, mdr_load, rf_wen, pc_wen};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic ir, input logic dr, input logic jbr, input logic ld,
                        input logic st, input logic wr, input logic [2:0] s,
                        input logic [7:0] strb, input int ret);
        vec_t v;
        v.ir = ir; v.dr = dr; v.jbr = jbr; v.ld = ld; v.st = st; v.wr = wr;
        v.exp_state = s; v.exp_strb = strb; v.exp_ret = 32'(ret);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ir, input logic dr, input logic jbr,
                         input logic ld, input logic st, input logic wr);
        imem_ready = ir; dmem_ready = dr;
        is_jbr = jbr; is_load = ld; is_store = st; is_wreg = wr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef CTRL_STEP_MODE_EN
        step = 1'b1;
`endif
        // ADDU
        addv(0,0,0,0,0,0, 3'd0, S_NONE, 0);
        addv(1,1,0,0,0,1, 3'd1, S_IFF,  0);
        addv(1,1,0,0,0,1, 3'd2, S_NONE, 0);
        addv(1,1,0,0,0,1, 3'd3, S_EXE,  0);
        addv(1,1,0,0,0,1, 3'd5, S_WB,   0);
        // LW with three MEM wait cycles
        addv(1,0,0,1,0,0, 3'd1, S_IFF,  1);
        addv(1,0,0,1,0,0, 3'd2, S_NONE, 1);
        addv(1,0,0,1,0,0, 3'd3, S_EXE,  1);
        addv(1,0,0,1,0,0, 3'd4, S_MEMW, 1);
        addv(1,0,0,1,0,0, 3'd4, S_MEMW, 1);
        addv(1,0,0,1,0,0, 3'd4, S_MEMW, 1);
        addv(1,1,0,1,0,0, 3'd4, S_MEMLD,1);
        addv(1,1,0,1,0,0, 3'd5, S_WB,   1);
        // SW with two IF wait cycles; dmem_ready high in IF is ignored
        addv(0,1,0,0,1,0, 3'd1, S_IFW,  2);
        addv(0,1,0,0,1,0, 3'd1, S_IFW,  2);
        addv(1,1,0,0,1,0, 3'd1, S_IFF,  2);
        addv(1,1,0,0,1,0, 3'd2, S_NONE, 2);
        addv(1,1,0,0,1,0, 3'd3, S_EXE,  2);
        addv(1,1,0,0,1,0, 3'd4, S_MEMST,2);
        // BEQ with is_wreg also set: jump wins
        addv(1,1,1,0,0,1, 3'd1, S_IFF,  3);
        addv(1,1,1,0,0,1, 3'd2, S_PC,   3);
        // no-effect instruction retires from EXE
        addv(1,1,0,0,0,0, 3'd1, S_IFF,  4);
        addv(1,1,0,0,0,0, 3'd2, S_NONE, 4);
        addv(1,1,0,0,0,0, 3'd3, S_EXEPC,4);
        addv(0,1,0,0,0,0, 3'd1, S_IFW,  5);
        // load and store both set: treated as load, no write
        addv(1,1,0,1,1,0, 3'd1, S_IFF,  5);
        addv(1,1,0,1,1,0, 3'd2, S_NONE, 5);
        addv(1,1,0,1,1,0, 3'd3, S_EXE,  5);
        addv(1,1,0,1,1,0, 3'd4, S_MEMLD,5);
        addv(1,1,0,1,1,0, 3'd5, S_WB,   5);
        addv(0,0,0,0,0,0, 3'd1, S_IFW,  6);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",   32'(state),     32'd0);
        chk("reset_strobes", 32'(strobes()), 32'd0);
        chk("reset_retired", retired,        32'd0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ir, vecs[i].dr, vecs[i].jbr, vecs[i].ld, vecs[i].st, vecs[i].wr);
            @(negedge clk);
            chk($sformatf("v%0d_state", i),   32'(state),     32'(vecs[i].exp_state));
            chk($sformatf("v%0d_strobes", i), 32'(strobes()), 32'(vecs[i].exp_strb));
            chk($sformatf("v%0d_retired", i), retired,        vecs[i].exp_ret);
            chk($sformatf("v%0d_wrap_ret", i), 32'(w_retired), vecs[i].exp_ret % 32'd4);
            next_cycle();
        end

        // Store stalled in MEM, then async reset mid-cycle
        drive(1, 0, 0, 0, 1, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("mem_stall_state", 32'(state),    32'd4);
        chk("mem_stall_req",   32'(dmem_req), 32'd1);
        chk("mem_stall_wen",   32'(dmem_wen), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_req",     32'(dmem_req),  32'd0);
        chk("async_rst_wen",     32'(dmem_wen),  32'd0);
        chk("async_rst_pc_wen",  32'(pc_wen),    32'd0);
        chk("async_rst_state",   32'(state),     32'd0);
        chk("async_rst_retired", retired,        32'd0);
        chk("async_rst_wrap",    32'(w_retired), 32'd0);
        next_cycle();
        resetn = 1'b1;

        // ALU op after reset: IDLE bubble then IF/ID/EXE/WB
        drive(1, 1, 0, 0, 0, 1);
        chk("post_rst_idle", 32'(state), 32'd0);
        next_cycle();
        chk("post_rst_if", 32'(state), 32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("post_rst_wb_strobes", 32'(strobes()), 32'(S_WB));
        next_cycle();
        chk("post_rst_retired", retired, 32'd1);
        chk("post_rst_state",   32'(state), 32'd1);

`ifdef CTRL_STEP_MODE_EN
        // Step mode: parked in IF until a single step pulse
        resetn = 1'b0;
        step = 1'b0;
        next_cycle();
        resetn = 1'b1;
        repeat (11) next_cycle();
        chk("step_park_state", 32'(state),    32'd1);
        chk("step_park_req",   32'(imem_req), 32'd0);
        step = 1'b1;
        #1;
        chk("step_fetch_req", 32'(imem_req), 32'd1);
        next_cycle();
        step = 1'b0;
        repeat (8) next_cycle();
        chk("step_retired",    retired,       32'd1);
        chk("step_park2_state", 32'(state),   32'd1);
        chk("step_park2_req",  32'(imem_req), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
